// File: rtl/boot_loader.sv
// Program loader: streams words from a valid/ready source into RAM, then
// releases the CPU from reset after a fixed hold interval.
module boot_loader #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]         HOLD_INIT = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]         HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0]         HOLD_ZERO = HW'(0);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = (ADDR_WIDTH + 1)'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_ptr, w_ptr;
  logic [ADDR_WIDTH:0]   r_count, w_count;
  logic [HW-1:0]         r_hold_cnt, w_hold_cnt;
  logic                  r_s_ready, w_s_ready;
  logic                  r_mem_we, w_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;
  logic                  r_cpu_hold, w_cpu_hold;
  logic                  r_done, w_done;
  logic                  r_error, w_error;
  logic                  w_accept;

  assign w_accept = s_valid & r_s_ready;

  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_count     = r_count;
    w_hold_cnt  = r_hold_cnt;
    w_s_ready   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_cpu_hold  = 1'b1;
    w_done      = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state   = S_LOAD;
          w_ptr     = BASE_ADDR;
          w_count   = CNT_ZERO;
          w_s_ready = 1'b1;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_LOAD: begin
        w_s_ready = 1'b1;
        if (w_accept) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_ptr;
          w_mem_wdata = s_data;
          w_count     = r_count + CNT_ONE;
          // The pointer saturates at the top of RAM; it is never reused past there.
          if (r_ptr != LAST_ADDR) begin
            w_ptr = r_ptr + PTR_ONE;
          end else begin
            w_ptr = r_ptr;
          end
          if (s_last) begin
            w_state    = S_HOLD;
            w_s_ready  = 1'b0;
            w_hold_cnt = HOLD_INIT;
          end else if (r_ptr == LAST_ADDR) begin
            w_state   = S_ERROR;
            w_s_ready = 1'b0;
            w_error   = 1'b1;
          end else begin
            w_state = S_LOAD;
          end
        end else begin
          w_state = S_LOAD;
        end
      end
      S_HOLD: begin
        // Counter starts on the write edge, so release lands HOLD_CYCLES after mem_we falls.
        if (r_hold_cnt == HOLD_ZERO) begin
          w_state    = S_RUN;
          w_cpu_hold = 1'b0;
          w_done     = 1'b1;
        end else begin
          w_hold_cnt = r_hold_cnt - HOLD_ONE;
        end
      end
      S_RUN: begin
        if (start) begin
          w_state   = S_LOAD;
          w_ptr     = BASE_ADDR;
          w_count   = CNT_ZERO;
          w_s_ready = 1'b1;
        end else begin
          w_cpu_hold = 1'b0;
          w_done     = 1'b1;
        end
      end
      S_ERROR: begin
        if (start) begin
          w_state   = S_LOAD;
          w_ptr     = BASE_ADDR;
          w_count   = CNT_ZERO;
          w_s_ready = 1'b1;
        end else begin
          w_error = 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= BASE_ADDR;
      r_count     <= CNT_ZERO;
      r_hold_cnt  <= HOLD_ZERO;
      r_s_ready   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_ptr       <= w_ptr;
      r_count     <= w_count;
      r_hold_cnt  <= w_hold_cnt;
      r_s_ready   <= w_s_ready;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_cpu_hold  <= w_cpu_hold;
      r_done      <= w_done;
      r_error     <= w_error;
    end
  end

  assign s_ready    = r_s_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_count;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized self-checking bench for boot_loader: three instances cover the
// default geometry, a 4-word RAM (overflow / exact fit) and a non-zero base.
module tb_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a   [3];
  logic        s_valid_a [3];
  logic [31:0] s_data_a  [3];
  logic        s_last_a  [3];

  logic        d0_ready, d0_we, d0_hold, d0_done, d0_err;
  logic [7:0]  d0_addr;
  logic [31:0] d0_wdata;
  logic [8:0]  d0_wc;
  logic        d1_ready, d1_we, d1_hold, d1_done, d1_err;
  logic [1:0]  d1_addr;
  logic [31:0] d1_wdata;
  logic [2:0]  d1_wc;
  logic        d2_ready, d2_we, d2_hold, d2_done, d2_err;
  logic [7:0]  d2_addr;
  logic [31:0] d2_wdata;
  logic [8:0]  d2_wc;

  boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(8'h00), .HOLD_CYCLES(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .s_valid(s_valid_a[0]), .s_data(s_data_a[0]),
    .s_last(s_last_a[0]), .s_ready(d0_ready), .mem_we(d0_we), .mem_addr(d0_addr),
    .mem_wdata(d0_wdata), .cpu_hold(d0_hold), .done(d0_done), .error(d0_err), .word_count(d0_wc));

  boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .BASE_ADDR(2'd0), .HOLD_CYCLES(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .s_valid(s_valid_a[1]), .s_data(s_data_a[1]),
    .s_last(s_last_a[1]), .s_ready(d1_ready), .mem_we(d1_we), .mem_addr(d1_addr),
    .mem_wdata(d1_wdata), .cpu_hold(d1_hold), .done(d1_done), .error(d1_err), .word_count(d1_wc));

  boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(8'h10), .HOLD_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .s_valid(s_valid_a[2]), .s_data(s_data_a[2]),
    .s_last(s_last_a[2]), .s_ready(d2_ready), .mem_we(d2_we), .mem_addr(d2_addr),
    .mem_wdata(d2_wdata), .cpu_hold(d2_hold), .done(d2_done), .error(d2_err), .word_count(d2_wc));

  int          cur = 0;
  logic        ob_ready, ob_we, ob_hold, ob_done, ob_err;
  logic [7:0]  ob_addr;
  logic [31:0] ob_wdata;
  logic [8:0]  ob_wc;

  // Select the instance currently under test
  always_comb begin
    ob_ready = d0_ready; ob_we = d0_we; ob_hold = d0_hold; ob_done = d0_done;
    ob_err = d0_err; ob_addr = d0_addr; ob_wdata = d0_wdata; ob_wc = d0_wc;
    if (cur == 1) begin
      ob_ready = d1_ready; ob_we = d1_we; ob_hold = d1_hold; ob_done = d1_done;
      ob_err = d1_err; ob_addr = 8'(d1_addr); ob_wdata = d1_wdata; ob_wc = 9'(d1_wc);
    end else if (cur == 2) begin
      ob_ready = d2_ready; ob_we = d2_we; ob_hold = d2_hold; ob_done = d2_done;
      ob_err = d2_err; ob_addr = d2_addr; ob_wdata = d2_wdata; ob_wc = d2_wc;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 64'(ob_ready), 64'd0);
    check_val({tag, "_we"},    64'(ob_we),    64'd0);
    check_val({tag, "_addr"},  64'(ob_addr),  64'd0);
    check_val({tag, "_wdata"}, 64'(ob_wdata), 64'd0);
    check_val({tag, "_hold"},  64'(ob_hold),  64'd1);
    check_val({tag, "_done"},  64'(ob_done),  64'd0);
    check_val({tag, "_err"},   64'(ob_err),   64'd0);
    check_val({tag, "_wc"},    64'(ob_wc),    64'd0);
  endtask

  // Reference behaviour: the k-th accepted word goes to base+k the cycle after
  // acceptance; loading stops on the last word or when RAM from base is full.
  task automatic do_load(input int sel, input int n, input int last_idx, input int dens,
                         input logic [15:0] pat, input int pat_len, input bit fixed,
                         input int abort_at);
    int base, capw, hcyc, idx, cyc;
    bit rdy, v, got_last;
    logic [31:0] d;
    cur  = sel;
    base = (sel == 2) ? 16 : 0;
    capw = (sel == 1) ? 4 : (256 - base);
    hcyc = (sel == 2) ? 2 : 4;
    @(negedge clk); start_a[sel] = 1'b1;
    @(negedge clk); start_a[sel] = 1'b0;
    check_val("start_hold", 64'(ob_hold), 64'd1);
    check_val("start_done", 64'(ob_done), 64'd0);
    check_val("start_err",  64'(ob_err),  64'd0);
    check_val("start_wc",   64'(ob_wc),   64'd0);
    idx = 0; cyc = 0; rdy = 1'b1; got_last = 1'b0;
    while (rdy && cyc < 400 && idx != abort_at) begin
      check_val("s_ready", 64'(ob_ready), 64'(rdy));
      check_val("load_hold", 64'(ob_hold), 64'd1);
      if (pat_len > 0) v = (cyc < pat_len) ? pat[cyc] : 1'b1;
      else             v = ($urandom_range(99) < dens);
      if (idx >= n) v = 1'b0;
      d = fixed ? 32'(32'h11 * (idx + 1)) : $urandom;
      s_valid_a[sel] = v;
      s_data_a[sel]  = d;
      s_last_a[sel]  = v ? (idx == last_idx) : 1'($urandom_range(1));
      @(negedge clk); cyc++;
      check_val("mem_we", 64'(ob_we), 64'(v));
      if (v) begin
        check_val("mem_addr",  64'(ob_addr),  64'(base + idx));
        check_val("mem_wdata", 64'(ob_wdata), 64'(d));
        if (idx == last_idx) begin
          rdy = 1'b0; got_last = 1'b1;
        end else if (idx + 1 == capw) begin
          rdy = 1'b0;
        end
        idx++;
      end
    end
    s_valid_a[sel] = 1'b0;
    s_last_a[sel]  = 1'b0;
    if (idx == abort_at) return;
    if (rdy) begin
      check_val("load_timeout", 64'd1, 64'd0);
      return;
    end
    check_val("word_count", 64'(ob_wc), 64'(idx));
    check_val("ready_drop", 64'(ob_ready), 64'd0);
    if (got_last) begin
      for (int j = 1; j <= hcyc + 1; j++) begin
        @(negedge clk);
        check_val("hold_phase", 64'(ob_hold), (j <= hcyc) ? 64'd1 : 64'd0);
        check_val("done_phase", 64'(ob_done), (j <= hcyc) ? 64'd0 : 64'd1);
        check_val("hold_we",    64'(ob_we),   64'd0);
      end
      check_val("run_err", 64'(ob_err), 64'd0);
      check_val("run_wc",  64'(ob_wc),  64'(idx));
    end else begin
      check_val("ovf_err",  64'(ob_err),  64'd1);
      check_val("ovf_hold", 64'(ob_hold), 64'd1);
      check_val("ovf_done", 64'(ob_done), 64'd0);
      for (int j = 0; j < 3; j++) begin
        s_valid_a[sel] = 1'b1;
        s_data_a[sel]  = $urandom;
        @(negedge clk);
        check_val("ovf_no_we", 64'(ob_we),    64'd0);
        check_val("ovf_ready", 64'(ob_ready), 64'd0);
        check_val("ovf_err2",  64'(ob_err),   64'd1);
        check_val("ovf_wc",    64'(ob_wc),    64'(idx));
      end
      s_valid_a[sel] = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0; s_valid_a[i] = 1'b0; s_data_a[i] = 32'd0; s_last_a[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    cur = 0;
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    // Basic back-to-back load 0x11..0x44
    do_load(0, 4, 3, 100, 16'h0000, 0, 1'b1, -1);
    // Source stalls, starting from RUN
    do_load(0, 4, 3, 0, 16'h0059, 7, 1'b0, -1);
    for (int r = 0; r < 5; r++) begin
      int n;
      n = $urandom_range(12, 1);
      do_load(0, n, n - 1, 60, 16'h0000, 0, 1'b0, -1);
    end
    // Overflow, then exact fit starting from ERROR
    do_load(1, 5, -1, 100, 16'h0000, 0, 1'b0, -1);
    do_load(1, 4, 3, 100, 16'h0000, 0, 1'b0, -1);
    do_load(1, 6, -1, 50, 16'h0000, 0, 1'b0, -1);
    do_load(1, 4, 3, 70, 16'h0000, 0, 1'b0, -1);
    // Non-zero base, then reload from RUN
    do_load(2, 3, 2, 80, 16'h0000, 0, 1'b0, -1);
    do_load(2, 2, 1, 100, 16'h0000, 0, 1'b0, -1);

    // Reset mid-load after two words
    do_load(0, 4, 3, 100, 16'h0000, 0, 1'b0, 2);
    cur = 0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    start_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_start");
    start_a[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");
    do_load(0, 4, 3, 75, 16'h0000, 0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
